// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the two-requester ALU arbiter:
//     - default operand/result and shift-immediate widths
//     - opcode encodings for the shared add / shift-left unit
//     - FSM state encoding of the arbiter
//     - round-robin winner selection helper
// ---------------------------------------------------------------------------
package alu_pkg;

    // Default widths; the arbiter and ALU take them as parameter defaults.
    localparam int ALU_DATA_W = 8;
    localparam int ALU_IMM_W  = 3;

    // Opcode encoding carried on reqN_opcode.
    localparam logic OP_SHL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Arbiter FSM: IDLE accepts, EXEC runs the ALU, RESP holds the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Round-robin pick between two requesters.
    //   A lone valid request always wins. On a tie the requester that did
    //   not win last time is chosen, so neither side can be starved.
    function automatic logic pick_winner(
        input logic valid0,
        input logic valid1,
        input logic last_grant
    );
        logic winner;
        if (valid0 && valid1) begin
            winner = ~last_grant;
        end else begin
            winner = valid1;
        end
        return winner;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
//   Purely combinational add / shift-left unit shared by both requesters.
//   All state lives in the arbiter; this block only maps the captured
//   operation to a result.
//
// Ports
//   opcode  in   1        OP_ADD = a + b, OP_SHL = b << imm
//   a       in   DATA_W   add operand (ignored for shift)
//   b       in   DATA_W   add operand / shift source
//   imm     in   IMM_W    shift amount
//   result  out  DATA_W   add result mod 2^DATA_W, or zero-filled shift
// ---------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int IMM_W  = ALU_IMM_W
) (
    input  logic              opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        if (opcode == OP_ADD) begin
            // Sum is truncated to DATA_W bits, so the carry is dropped.
            result = a + b;
        end else if (int'(imm) < DATA_W) begin
            // Shifts of DATA_W or more keep the default of zero; the
            // explicit guard keeps that true for any IMM_W/DATA_W pairing.
            result = b << imm;
        end
    end

endmodule : alu_exec

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one alu_exec instance between two requesters. A round-robin
//   arbiter accepts one operation at a time, registers its operands, runs
//   it through the ALU and returns the result on a tagged response channel
//   that supports backpressure. Exactly one operation is in flight.
//
//   Handshakes: a transfer happens on a rising sysclk edge where valid and
//   ready are both high. reqN_ready is only raised in IDLE and only for the
//   arbitration winner, and it never depends on rsp_ready. rsp_valid, once
//   high, holds with rsp_id/rsp_data stable until rsp_ready is seen.
//
//   Timing: acceptance in cycle 0, EXEC in cycle 1, rsp_valid in cycle 2;
//   with rsp_ready high in cycle 2 the next request can be taken in cycle 3.
//
// Ports
//   sysclk        in   1       clock, rising edge
//   rst_n         in   1       asynchronous active-low reset
//   reqN_valid    in   1       requester N has an operation pending
//   reqN_ready    out  1       requester N's operation is accepted
//   reqN_opcode   in   1       1 = add, 0 = shift left
//   reqN_a        in   DATA_W  add operand a
//   reqN_b        in   DATA_W  add operand b / shift source
//   reqN_imm      in   IMM_W   shift amount
//   rsp_valid     out  1       result available
//   rsp_id        out  1       requester that issued the result
//   rsp_data      out  DATA_W  result
//   rsp_ready     in   1       consumer accepts the result
//   dbg_state     out  state_t current FSM state, for observation only
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int IMM_W  = ALU_IMM_W
) (
    input  logic              sysclk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [IMM_W-1:0]  req0_imm,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [IMM_W-1:0]  req1_imm,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,

    output state_t            dbg_state
);

    // -----------------------------------------------------------------------
    // State and captured operation
    // -----------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;

    logic              last_grant;
    logic              cap_opcode;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [IMM_W-1:0]  cap_imm;
    logic              cap_id;

    logic              win_id;
    logic              accept;
    logic              rsp_done;
    logic [DATA_W-1:0] alu_result;

    // -----------------------------------------------------------------------
    // Arbitration and next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        win_id     = pick_winner(req0_valid, req1_valid, last_grant);
        // rst_n is folded in so both readies read 0 for the whole time
        // reset is held, not just after the state register has cleared.
        accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !win_id;
        req1_ready = accept &&  win_id;
        rsp_done   = (state == RESP) && rsp_ready;

        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Operand capture on the request handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;     // req0 wins the first tie
            cap_opcode <= OP_SHL;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_imm    <= '0;
            cap_id     <= 1'b0;
        end else if (accept) begin
            last_grant <= win_id;
            cap_id     <= win_id;
            if (win_id) begin
                cap_opcode <= req1_opcode;
                cap_a      <= req1_a;
                cap_b      <= req1_b;
                cap_imm    <= req1_imm;
            end else begin
                cap_opcode <= req0_opcode;
                cap_a      <= req0_a;
                cap_b      <= req0_b;
                cap_imm    <= req0_imm;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shared ALU; it only ever sees registered operands.
    // -----------------------------------------------------------------------
    alu_exec #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu_exec (
        .opcode (cap_opcode),
        .a      (cap_a),
        .b      (cap_b),
        .imm    (cap_imm),
        .result (alu_result)
    );

    // -----------------------------------------------------------------------
    // Response register
    //   Loaded once, in EXEC, so the result is stable for the whole RESP
    //   stall. rsp_data is left untouched after the handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cap_id;
            rsp_data  <= alu_result;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed-vector bench for alu_arbiter. Inputs change 1 time unit after
//   a rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic       sysclk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_opcode;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_imm;
    logic       req1_valid, req1_ready, req1_opcode;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_imm;
    logic       rsp_valid, rsp_id, rsp_ready;
    logic [7:0] rsp_data;
    state_t     dbg_state;

    int vectors;
    int miscompares;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    alu_arbiter #(.DATA_W(8), .IMM_W(3)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_imm    (req0_imm),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_imm    (req1_imm),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .dbg_state   (dbg_state)
    );

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Driver helpers
    // -----------------------------------------------------------------------
    task automatic drive_req(input logic id, input logic op, input logic [7:0] a,
                             input logic [7:0] b, input logic [2:0] imm);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; req0_imm = imm;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; req1_imm = imm;
        end
    endtask

    // Clean reset; returns 1 time unit after the edge on which it released.
    task automatic reset_dut();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        // Both requesters valid while reset is held: no ready may appear.
        rst_n = 1'b0;
        drive_req(1'b0, OP_ADD, 8'h01, 8'h01, 3'd0);
        drive_req(1'b1, OP_ADD, 8'h02, 8'h02, 3'd0);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data} !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_rsp: valid=%b id=%b data=%h required 0 0 00", rsp_valid, rsp_id, rsp_data);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        @(negedge sysclk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_req_ready: got %b%b required 00", req0_ready, req1_ready);
        end
    endtask

    // One operation from IDLE with rsp_ready held high, checked cycle by cycle.
    task automatic do_op(input string name, input logic id, input logic op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] imm, input logic [7:0] exp);
        @(posedge sysclk);
        #1 rsp_ready = 1'b1;
        drive_req(id, op, a, b, imm);
        @(negedge sysclk);                      // cycle 0
        vectors++;
        if ({req0_ready, req1_ready} !== {~id, id}) begin
            miscompares++;
            $display("FAIL %s c0_ready: got %b%b required %b%b", name, req0_ready, req1_ready, ~id, id);
        end
        @(posedge sysclk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge sysclk);                      // cycle 1
        vectors++;
        if (rsp_valid !== 1'b0 || dbg_state !== EXEC) begin
            miscompares++;
            $display("FAIL %s c1_exec: rsp_valid=%b state=%0d required 0 %0d", name, rsp_valid, dbg_state, EXEC);
        end
        @(negedge sysclk);                      // cycle 2
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== exp) begin
            miscompares++;
            $display("FAIL %s c2_rsp: valid=%b id=%b data=%h required 1 %b %h", name, rsp_valid, rsp_id, rsp_data, id, exp);
        end
        @(negedge sysclk);                      // cycle 3
        vectors++;
        if (rsp_valid !== 1'b0 || dbg_state !== IDLE || rsp_data !== exp) begin
            miscompares++;
            $display("FAIL %s c3_idle: valid=%b state=%0d data=%h required 0 %0d %h", name, rsp_valid, dbg_state, rsp_data, IDLE, exp);
        end
    endtask

    task automatic test_ops();
        do_op("add_req0",       1'b0, OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80);
        do_op("add_req1_carry", 1'b1, OP_ADD, 8'hF0, 8'h20, 3'd0, 8'h10);
        do_op("shl_req1_3",     1'b1, OP_SHL, 8'hAA, 8'h81, 3'd3, 8'h08);
        do_op("shl_req0_7",     1'b0, OP_SHL, 8'h00, 8'hFF, 3'd7, 8'h80);
        do_op("shl_req0_0",     1'b0, OP_SHL, 8'h33, 8'h5A, 3'd0, 8'h5A);
        do_op("add_req1_wrap",  1'b1, OP_ADD, 8'hFF, 8'hFF, 3'd5, 8'hFE);
    endtask

    // Both requesters valid from reset: strict alternation, one result every 3 cycles.
    task automatic test_back_to_back();
        logic [2:0] exp_flags;
        logic       exp_id;
        logic [7:0] exp_data;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive_req(1'b0, OP_ADD, 8'h01, 8'h02, 3'd0);  // -> 0x03
        drive_req(1'b1, OP_SHL, 8'h00, 8'h01, 3'd4);  // -> 0x10
        repeat (2) @(posedge sysclk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge sysclk);
            exp_flags = {(k % 6 == 0), (k % 6 == 3), (k % 3 == 2)};
            vectors++;
            if ({req0_ready, req1_ready, rsp_valid} !== exp_flags) begin
                miscompares++;
                $display("FAIL b2b_flags k=%0d: ready0/ready1/rsp_valid=%b%b%b required %b", k, req0_ready, req1_ready, rsp_valid, exp_flags);
            end
            if (k % 3 == 2) begin
                exp_id   = (k % 6 == 5);
                exp_data = exp_id ? 8'h10 : 8'h03;
                vectors++;
                if (rsp_id !== exp_id || rsp_data !== exp_data) begin
                    miscompares++;
                    $display("FAIL b2b_rsp k=%0d: id=%b data=%h required %b %h", k, rsp_id, rsp_data, exp_id, exp_data);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Response stalled for 5 cycles with req0 waiting behind it.
    task automatic test_backpressure();
        reset_dut();
        @(posedge sysclk);
        #1 rsp_ready = 1'b0;
        drive_req(1'b1, OP_ADD, 8'h10, 8'h05, 3'd0);  // -> 0x15
        @(negedge sysclk);                              // cycle 0
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_accept: got %b%b required 01", req0_ready, req1_ready);
        end
        @(posedge sysclk);
        #1 req1_valid = 1'b0;
        drive_req(1'b0, OP_SHL, 8'h00, 8'h03, 3'd1);  // -> 0x06
        @(negedge sysclk);                              // cycle 1
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_exec_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        for (int i = 0; i < 5; i++) begin               // cycles 2..6
            @(negedge sysclk);
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== {1'b1, 1'b1, 8'h15, 2'b00}) begin
                miscompares++;
                $display("FAIL bp_hold i=%0d: valid=%b id=%b data=%h ready=%b%b required 1 1 15 00", i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready);
            end
        end
        @(posedge sysclk);
        #1 rsp_ready = 1'b1;
        @(negedge sysclk);                              // cycle 7: response handshake
        vectors++;
        if (rsp_valid !== 1'b1 || req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: valid=%b ready0=%b required 1 0", rsp_valid, req0_ready);
        end
        @(negedge sysclk);                              // cycle 8: back in IDLE
        vectors++;
        if (req0_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h15) begin
            miscompares++;
            $display("FAIL bp_next_accept: ready0=%b valid=%b data=%h required 1 0 15", req0_ready, rsp_valid, rsp_data);
        end
        @(posedge sysclk);
        #1 req0_valid = 1'b0;
        repeat (2) @(negedge sysclk);                   // cycle 10
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h06) begin
            miscompares++;
            $display("FAIL bp_second_rsp: valid=%b id=%b data=%h required 1 0 06", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    // Reset in EXEC drops the operation; afterwards req0 wins the first tie.
    task automatic test_reset_mid_exec();
        reset_dut();
        @(posedge sysclk);
        #1 rsp_ready = 1'b1;
        drive_req(1'b0, OP_ADD, 8'h11, 8'h22, 3'd0);
        @(negedge sysclk);
        @(posedge sysclk);
        #1 req0_valid = 1'b0;
        @(negedge sysclk);                              // in EXEC
        rst_n = 1'b0;
        drive_req(1'b0, OP_ADD, 8'h01, 8'h01, 3'd0);  // -> 0x02
        drive_req(1'b1, OP_ADD, 8'h02, 8'h02, 3'd0);  // -> 0x04
        #1;
        vectors++;
        if (dbg_state !== IDLE || rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset: state=%0d valid=%b ready=%b%b required %0d 0 00", dbg_state, rsp_valid, req0_ready, req1_ready, IDLE);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_no_rsp i=%0d: valid=%b required 0", i, rsp_valid);
            end
        end
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        @(negedge sysclk);
        vectors++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL tie_after_reset: ready=%b%b valid=%b required 10 0", req0_ready, req1_ready, rsp_valid);
        end
        @(posedge sysclk);
        #1 req0_valid = 1'b0;
        @(negedge sysclk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_exec: valid=%b required 0", rsp_valid);
        end
        @(negedge sysclk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h02) begin
            miscompares++;
            $display("FAIL tie_rsp0: valid=%b id=%b data=%h required 1 0 02", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge sysclk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL tie_grant1: ready=%b%b required 01", req0_ready, req1_ready);
        end
        @(posedge sysclk);
        #1 req1_valid = 1'b0;
        repeat (2) @(negedge sysclk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'h04) begin
            miscompares++;
            $display("FAIL tie_rsp1: valid=%b id=%b data=%h required 1 1 04", rsp_valid, rsp_id, rsp_data);
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_opcode = 1'b0; req0_a = '0; req0_b = '0; req0_imm = '0;
        req1_valid = 1'b0; req1_opcode = 1'b0; req1_a = '0; req1_b = '0; req1_imm = '0;

        test_reset();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_exec();

        repeat (2) @(posedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_arbiter
